// File: rtl/histo_readout_packer_if.sv
// Control, histogram and byte-stream signals between the readout packer and its
// neighbours: the requester, the histogram stage and the serial TX consumer.
interface histo_readout_packer_if #(
  parameter int unsigned NHIST = 8
);
  logic                  start;
  logic [3:0]            start_ch;
  logic [4:0]            nchans;
  logic                  clear_after;
  logic [32*NHIST-1:0]   histosin;
  logic [7:0]            histostosend;
  logic                  resethist;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  busy;
  logic                  done;

  modport master (
    output start, start_ch, nchans, clear_after, histosin, tx_ready,
    input  histostosend, resethist, tx_data, tx_valid, busy, done
  );

  modport slave (
    input  start, start_ch, nchans, clear_after, histosin, tx_ready,
    output histostosend, resethist, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/histo_readout_packer.sv
// Steps the histogram channel select over a window, captures each channel's words
// and emits them as 35-byte framed records (0xA5, channel, words MSB-first, XOR).
module histo_readout_packer #(
  parameter int unsigned NCHAN  = 16,
  parameter int unsigned NHIST  = 8,
  parameter int unsigned SETTLE = 3
) (
  input  logic                   clk_adc,
  input  logic                   rst,
  histo_readout_packer_if.slave  bus
);

  localparam int unsigned CW = $clog2(SETTLE) + 1;
  localparam int unsigned WW = $clog2(NHIST);
  localparam logic [5:0]  LAST_B = 6'(4 * NHIST + 2);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CAPTURE,
    SEND,
    CLEAR,
    DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [3:0]               ch_q, ch_d;
  logic [4:0]               k_q, k_d;
  logic [4:0]               n_q, n_d;
  logic                     clr_q, clr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [5:0]               b_q, b_d;
  logic [NHIST-1:0][31:0]   words_q, words_d;
  logic [3:0]               hts_q, hts_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic                     tx_valid_q, tx_valid_d;
  logic                     resethist_q, resethist_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;

  logic                     hshake;
  logic [4:0]               n_clamped;
  logic [5:0]               widx;
  logic [31:0]              sel_word;
  logic [7:0]               word_byte;
  logic [7:0]               csum;

  assign hshake    = tx_valid_q && bus.tx_ready;
  assign n_clamped = (bus.nchans > 5'(NCHAN)) ? 5'(NCHAN) : bus.nchans;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    k_d     = k_q;
    n_d     = n_q;
    clr_d   = clr_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    words_d = words_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ch_d  = bus.start_ch;
          k_d   = '0;
          n_d   = n_clamped;
          clr_d = bus.clear_after;
          cnt_d = '0;
          state_d = (n_clamped == '0) ? DONE : SELECT;
        end
      end
      SELECT: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        words_d = bus.histosin;
        b_d     = '0;
        state_d = SEND;
      end
      SEND: begin
        if (hshake) begin
          if (b_q == LAST_B) begin
            if (5'(k_q + 5'd1) < n_q) begin
              ch_d    = ch_q + 4'd1;
              k_d     = k_q + 5'd1;
              cnt_d   = '0;
              state_d = SELECT;
            end else begin
              // CLEAR is always passed through so done lands at the same cycle
              // whether or not the clear pulse is requested.
              state_d = CLEAR;
            end
          end else begin
            b_d = b_q + 6'd1;
          end
        end
      end
      CLEAR:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_comb begin
    widx     = b_d - 6'd2;
    sel_word = words_d[widx[WW+1:2]];
    case (widx[1:0])
      2'd0:    word_byte = sel_word[31:24];
      2'd1:    word_byte = sel_word[23:16];
      2'd2:    word_byte = sel_word[15:8];
      default: word_byte = sel_word[7:0];
    endcase

    csum = 8'hA5 ^ {4'h0, ch_d};
    for (int unsigned w = 0; w < NHIST; w++) begin
      csum = csum ^ words_d[w][31:24] ^ words_d[w][23:16] ^ words_d[w][15:8] ^ words_d[w][7:0];
    end

    tx_valid_d = (state_d == SEND);
    tx_data_d  = '0;
    if (state_d == SEND) begin
      if (b_d == 6'd0) begin
        tx_data_d = 8'hA5;
      end else if (b_d == 6'd1) begin
        tx_data_d = {4'h0, ch_d};
      end else if (b_d == LAST_B) begin
        tx_data_d = csum;
      end else begin
        tx_data_d = word_byte;
      end
    end

    hts_d       = (state_d == SELECT) ? ch_d : hts_q;
    resethist_d = (state_d == CLEAR) && clr_q;
    done_d      = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk_adc) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      k_q         <= '0;
      n_q         <= '0;
      clr_q       <= 1'b0;
      cnt_q       <= '0;
      b_q         <= '0;
      words_q     <= '0;
      hts_q       <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      resethist_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      k_q         <= k_d;
      n_q         <= n_d;
      clr_q       <= clr_d;
      cnt_q       <= cnt_d;
      b_q         <= b_d;
      words_q     <= words_d;
      hts_q       <= hts_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      resethist_q <= resethist_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.histostosend = {4'h0, hts_q};
  assign bus.tx_data      = tx_data_q;
  assign bus.tx_valid     = tx_valid_q;
  assign bus.resethist    = resethist_q;
  assign bus.done         = done_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_histo_readout_packer.sv
// Bench for histo_readout_packer: a histogram-stage model feeds channel-dependent words,
// expected frame bytes are queued at request time and popped on each TX handshake.
module tb_histo_readout_packer;

  logic        clk_adc = 1'b0;
  logic        rst     = 1'b1;
  logic [31:0] noise   = '0;
  logic [255:0] hin;

  always #5 clk_adc = ~clk_adc;

  histo_readout_packer_if #(.NHIST(8)) bus ();

  histo_readout_packer #(.NCHAN(16), .NHIST(8), .SETTLE(3)) dut (
    .clk_adc (clk_adc),
    .rst     (rst),
    .bus     (bus)
  );

  function automatic logic [31:0] word_f(input logic [3:0] ch, input int unsigned k);
    return (32'h0102_0300 + k) ^ (32'(ch ^ 4'd2) * 32'h1010_1010);
  endfunction

  // Histogram stage model; words are scrambled while a frame is on the wire.
  always_comb begin
    hin = '0;
    for (int k = 0; k < 8; k++) begin
      hin[32*k +: 32] = word_f(bus.histostosend[3:0], k) ^ (bus.tx_valid ? noise : 32'h0);
    end
  end
  assign bus.histosin = hin;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  int          hs_cyc[$];
  int          first_valid, last_hs, done_c, rh_c, rh_cnt, hs_cnt;
  logic [7:0]  hts_at1;

  task automatic step();
    @(posedge clk_adc);
    #1;
  endtask

  task automatic push_frame(input logic [3:0] ch);
    logic [7:0]  x;
    logic [7:0]  bt;
    logic [31:0] w;
    exp_q.push_back(8'hA5);
    x  = 8'hA5;
    bt = {4'h0, ch};
    exp_q.push_back(bt);
    x = x ^ bt;
    for (int k = 0; k < 8; k++) begin
      w = word_f(ch, k);
      for (int j = 0; j < 4; j++) begin
        bt = w[31 - 8*j -: 8];
        exp_q.push_back(bt);
        x = x ^ bt;
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic run(input logic [3:0] sch, input logic [4:0] nch, input logic clr,
                     input bit rnd, input int busy_start_c, input int budget);
    int         n_eff;
    int         c;
    bit         fin;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic [7:0] got;
    n_eff = (nch > 5'd16) ? 16 : int'(nch);
    for (int f = 0; f < n_eff; f++) push_frame(4'(int'(sch) + f));
    first_valid = -1; last_hs = -1; done_c = -1; rh_c = -1; rh_cnt = 0; hs_cnt = 0;
    hs_cyc.delete();
    prev_stall = 1'b0; prev_data = '0; fin = 1'b0;
    bus.start_ch = sch; bus.nchans = nch; bus.clear_after = clr; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.start_ch = ~sch; bus.nchans = 5'd7; bus.clear_after = ~clr;
    hts_at1 = bus.histostosend;
    c = 1;
    while (!fin && c <= budget) begin
      bus.start = (c == busy_start_c);
      n_checks++;
      if (bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL busy c=%0d: got %b expected 1", c, bus.busy);
      end
      if (bus.tx_valid === 1'b1 && first_valid < 0) first_valid = c;
      if (prev_stall) begin
        n_checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data) begin
          n_fail++;
          $display("FAIL stall_hold c=%0d: got valid=%b data=%h expected valid=1 data=%h",
                   c, bus.tx_valid, bus.tx_data, prev_data);
        end
      end
      bus.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.tx_valid === 1'b1 && bus.tx_ready) begin
        hs_cnt++; last_hs = c; hs_cyc.push_back(c);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL extra_byte c=%0d: got %h expected none", c, bus.tx_data);
        end else begin
          got = exp_q.pop_front();
          if (bus.tx_data !== got) begin
            n_fail++; $display("FAIL byte c=%0d: got %h expected %h", c, bus.tx_data, got);
          end
        end
      end
      prev_stall = (bus.tx_valid === 1'b1) && !bus.tx_ready;
      prev_data  = bus.tx_data;
      if (bus.resethist === 1'b1) begin rh_cnt++; rh_c = c; end
      if (bus.done === 1'b1) begin done_c = c; fin = 1'b1; end
      noise = $urandom;
      step();
      c++;
    end
    bus.start = 1'b0;
    bus.tx_ready = 1'b1;
    n_checks++;
    if (!fin) begin
      n_fail++; $display("FAIL done_timeout: got no done in %0d cycles expected done", budget);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL missing_bytes: got %0d left expected 0", exp_q.size());
    end
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after: got busy=%b valid=%b done=%b expected 0 0 0",
                 bus.busy, bus.tx_valid, bus.done);
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.start_ch = '0; bus.nchans = '0; bus.clear_after = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({bus.tx_valid, bus.busy, bus.done, bus.resethist} !== 4'b0 ||
        bus.histostosend !== 8'h00 || bus.tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b b=%b d=%b r=%b hts=%h data=%h expected all 0",
               bus.tx_valid, bus.busy, bus.done, bus.resethist, bus.histostosend, bus.tx_data);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_frame();
    run(4'd2, 5'd1, 1'b0, 1'b0, -1, 200);
    n_checks++; if (hts_at1 !== 8'h02) begin n_fail++; $display("FAIL hts_t1: got %h expected 02", hts_at1); end
    n_checks++; if (first_valid != 5) begin n_fail++; $display("FAIL first_valid: got %0d expected 5", first_valid); end
    n_checks++; if (last_hs != 39) begin n_fail++; $display("FAIL last_byte: got %0d expected 39", last_hs); end
    n_checks++; if (done_c != 41) begin n_fail++; $display("FAIL done_cycle: got %0d expected 41", done_c); end
    n_checks++; if (rh_cnt != 0) begin n_fail++; $display("FAIL resethist_cnt: got %0d expected 0", rh_cnt); end
    n_checks++; if (hs_cnt != 35) begin n_fail++; $display("FAIL byte_count: got %0d expected 35", hs_cnt); end
  endtask

  task automatic test_wrap();
    run(4'd15, 5'd3, 1'b0, 1'b0, -1, 400);
    n_checks++; if (hs_cnt != 105) begin n_fail++; $display("FAIL wrap_count: got %0d expected 105", hs_cnt); end
    n_checks++;
    if (hs_cyc.size() < 36 || hs_cyc[35] - hs_cyc[34] != 5) begin
      n_fail++; $display("FAIL chan_gap: got size=%0d expected gap 5", hs_cyc.size());
    end
  endtask

  task automatic test_backpressure();
    run(4'd2, 5'd1, 1'b0, 1'b1, -1, 2000);
    n_checks++; if (hs_cnt != 35) begin n_fail++; $display("FAIL bp_count: got %0d expected 35", hs_cnt); end
    n_checks++; if (done_c != last_hs + 2) begin n_fail++; $display("FAIL bp_done: got %0d expected %0d", done_c, last_hs + 2); end
  endtask

  task automatic test_zero_and_clamp();
    run(4'd4, 5'd0, 1'b0, 1'b0, -1, 20);
    n_checks++; if (done_c != 1) begin n_fail++; $display("FAIL zero_done: got %0d expected 1", done_c); end
    n_checks++; if (first_valid != -1) begin n_fail++; $display("FAIL zero_valid: got %0d expected -1", first_valid); end
    run(4'd5, 5'd20, 1'b0, 1'b0, -1, 2000);
    n_checks++; if (hs_cnt != 560) begin n_fail++; $display("FAIL clamp_count: got %0d expected 560", hs_cnt); end
  endtask

  task automatic test_clear_after();
    run(4'd6, 5'd2, 1'b1, 1'b0, -1, 400);
    n_checks++; if (rh_cnt != 1) begin n_fail++; $display("FAIL clear_cnt: got %0d expected 1", rh_cnt); end
    n_checks++; if (rh_c != last_hs + 1) begin n_fail++; $display("FAIL clear_cycle: got %0d expected %0d", rh_c, last_hs + 1); end
    n_checks++; if (done_c != last_hs + 2) begin n_fail++; $display("FAIL clear_done: got %0d expected %0d", done_c, last_hs + 2); end
  endtask

  task automatic test_reset_abort();
    int  hs;
    bit  found;
    bit  bad;
    push_frame(4'd3);
    hs = 0; found = 1'b0; bad = 1'b0;
    bus.tx_ready = 1'b1;
    bus.start_ch = 4'd3; bus.nchans = 5'd2; bus.clear_after = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (bus.tx_valid === 1'b1 && hs == 10) begin
        found = 1'b1;
      end else begin
        if (bus.tx_valid === 1'b1) hs++;
        step();
      end
    end
    n_checks++;
    if (!found || bus.tx_data !== exp_q[10]) begin
      n_fail++; $display("FAIL abort_byte10: got found=%b data=%h expected %h", found, bus.tx_data, exp_q[10]);
    end
    exp_q.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.histostosend !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_state: got v=%b b=%b hts=%h expected 0 0 00", bus.tx_valid, bus.busy, bus.histostosend);
    end
    for (int c = 0; c < 60; c++) begin
      if (bus.resethist !== 1'b0 || bus.done !== 1'b0 || bus.tx_valid !== 1'b0) bad = 1'b1;
      step();
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL abort_quiet: got pulse after abort expected none"); end
  endtask

  task automatic test_busy_start();
    run(4'd7, 5'd1, 1'b0, 1'b0, 20, 200);
    n_checks++; if (hs_cnt != 35) begin n_fail++; $display("FAIL busy_start_count: got %0d expected 35", hs_cnt); end
    n_checks++; if (done_c != 41) begin n_fail++; $display("FAIL busy_start_done: got %0d expected 41", done_c); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_wrap();
    test_backpressure();
    test_zero_and_clamp();
    test_clear_after();
    test_reset_abort();
    test_busy_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
